// File: rtl/wave_cordic_sched.sv
// Round-robin scheduler that time-shares one CORDIC core between NCH waveform channels.
// Handshake: a channel holds req high until its one-cycle ack; results return on out_valid/out_ch.
module wave_cordic_sched #(
    parameter int NCH     = 4,
    parameter int ANGLE_W = 16,
    parameter int DATA_W  = 12,
    parameter int X_INIT  = 1215,
    parameter int TMO     = 63,
    localparam int CW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [NCH-1:0]         req,
    input  logic [NCH*ANGLE_W-1:0] ch_angle,
    output logic [NCH-1:0]         ack,
    output logic                   cordic_start,
    output logic [ANGLE_W-1:0]     cordic_angle,
    output logic [DATA_W-1:0]      cordic_x,
    output logic [DATA_W-1:0]      cordic_y,
    input  logic                   cordic_done,
    input  logic [DATA_W-1:0]      cordic_sin,
    input  logic [DATA_W-1:0]      cordic_cos,
    output logic                   out_valid,
    output logic [CW-1:0]          out_ch,
    output logic [DATA_W-1:0]      out_sin,
    output logic [DATA_W-1:0]      out_cos,
    output logic                   err_timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        DELIVER = 2'd3
    } state_t;

    localparam logic [7:0] TMO_C = 8'(TMO);

    state_t               state_q;
    logic [CW-1:0]        last_grant_q;
    logic [CW-1:0]        cur_ch_q;
    logic [7:0]           cnt_q;
    logic [NCH-1:0]       ack_q;
    logic                 start_q;
    logic [ANGLE_W-1:0]   angle_q;
    logic [DATA_W-1:0]    x_q;
    logic [DATA_W-1:0]    y_q;
    logic                 out_valid_q;
    logic [CW-1:0]        out_ch_q;
    logic [DATA_W-1:0]    sin_q;
    logic [DATA_W-1:0]    cos_q;
    logic                 err_q;

    logic                 gnt_vld_d;
    logic [CW-1:0]        gnt_ch_d;
    logic [ANGLE_W-1:0]   gnt_angle_d;
    logic [NCH-1:0]       ack_d;

    // Search starts one past the last grant so every requester is served within NCH grants.
    always_comb begin
        gnt_vld_d = 1'b0;
        gnt_ch_d  = '0;
        for (int i = 1; i <= NCH; i++) begin
            if (!gnt_vld_d && req[(int'(last_grant_q) + i) % NCH]) begin
                gnt_vld_d = 1'b1;
                gnt_ch_d  = CW'((int'(last_grant_q) + i) % NCH);
            end
        end
        gnt_angle_d = ch_angle[int'(gnt_ch_d)*ANGLE_W +: ANGLE_W];
        ack_d = '0;
        for (int i = 0; i < NCH; i++) begin
            ack_d[i] = gnt_vld_d && (int'(gnt_ch_d) == i);
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q      <= IDLE;
            last_grant_q <= CW'(NCH - 1);
            cur_ch_q     <= '0;
            cnt_q        <= '0;
            ack_q        <= '0;
            start_q      <= 1'b0;
            angle_q      <= '0;
            x_q          <= '0;
            y_q          <= '0;
            out_valid_q  <= 1'b0;
            out_ch_q     <= '0;
            sin_q        <= '0;
            cos_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            ack_q       <= '0;
            start_q     <= 1'b0;
            out_valid_q <= 1'b0;
            x_q         <= DATA_W'(X_INIT);
            y_q         <= '0;
            case (state_q)
                IDLE: begin
                    if (gnt_vld_d) begin
                        ack_q        <= ack_d;
                        angle_q      <= gnt_angle_d;
                        cur_ch_q     <= gnt_ch_d;
                        last_grant_q <= gnt_ch_d;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    start_q <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    // A done arriving on the final allowed cycle still wins over the timeout.
                    if (cordic_done) begin
                        sin_q       <= cordic_sin;
                        cos_q       <= cordic_cos;
                        out_valid_q <= 1'b1;
                        out_ch_q    <= cur_ch_q;
                        state_q     <= DELIVER;
                    end else if (cnt_q + 8'd1 == TMO_C) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                DELIVER: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack          = ack_q;
    assign cordic_start = start_q;
    assign cordic_angle = angle_q;
    assign cordic_x     = x_q;
    assign cordic_y     = y_q;
    assign out_valid    = out_valid_q;
    assign out_ch       = out_ch_q;
    assign out_sin      = sin_q;
    assign out_cos      = cos_q;
    assign err_timeout  = err_q;

endmodule

// File: doc/wave_cordic_sched.md
WAVE_CORDIC_SCHED -- requirements
Module: wave_cordic_sched

Interface
REQ-001 Parameter NCH, default 4: number of waveform channels sharing one CORDIC core.
REQ-002 Parameter ANGLE_W, default 16: width of angle words.
REQ-003 Parameter DATA_W, default 12: width of x/y/sin/cos words, two's complement.
REQ-004 Parameter X_INIT, default 1215: CORDIC x seed (2000*0.6073).
REQ-005 Parameter TMO, default 63: maximum WAIT cycles before abort; range 1..255.
REQ-006 The port list SHALL be exactly:
 - clock  in  1  rising-edge clock.
 - resetn  in  1  reset; synchronous, active-low.
 - req  in  NCH  per-channel conversion request, level; held until ack.
 - ch_angle  in  NCH*ANGLE_W  channel i angle at bits [i*ANGLE_W +: ANGLE_W].
 - ack  out  NCH  one-hot one-cycle pulse; request accepted.
 - cordic_start  out  1  one-cycle start pulse to the core.
 - cordic_angle  out  ANGLE_W  angle to the core.
 - cordic_x  out  DATA_W  x seed.
 - cordic_y  out  DATA_W  y seed.
 - cordic_done  in  1  core result-valid pulse.
 - cordic_sin  in  DATA_W  core sine result.
 - cordic_cos  in  DATA_W  core cosine result.
 - out_valid  out  1  one-cycle result strobe.
 - out_ch  out  clog2(NCH)  channel index of the result.
 - out_sin  out  DATA_W  registered sine.
 - out_cos  out  DATA_W  registered cosine.
 - err_timeout  out  1  sticky timeout flag.

Function
REQ-007 All outputs SHALL be registered.
REQ-008 FSM states SHALL be IDLE, ISSUE, WAIT and DELIVER.
REQ-009 IDLE: with any req bit high, the block SHALL grant one channel by round-robin, searching from (last_grant+1) mod NCH upward with wrap-around, and SHALL go to ISSUE next cycle.
REQ-010 The grant cycle SHALL pulse ack[g] for one cycle, latch ch_angle[g] into cordic_angle, and latch g as the current channel.
REQ-011 ISSUE: cordic_start=1 for exactly one cycle, then go to WAIT.
REQ-012 cordic_x SHALL be X_INIT and cordic_y SHALL be 0 in every state except reset.
REQ-013 WAIT: on cordic_done=1, the block SHALL capture cordic_sin/cos into out_sin/out_cos and go to DELIVER.
REQ-014 cordic_done SHALL be ignored in IDLE, ISSUE and DELIVER.
REQ-015 DELIVER: out_valid=1 and out_ch=current channel for one cycle, then IDLE.
REQ-016 Request-to-result latency SHALL be grant cycle + 1 (ISSUE) + core latency + 1 (DELIVER).
REQ-017 WAIT timeout: a counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-018 If the counter reaches TMO without cordic_done, the block SHALL set err_timeout, go to IDLE without out_valid, and still advance last_grant.
REQ-019 cordic_done arriving in the same cycle the counter reaches TMO SHALL be treated as success: no error, result delivered.
REQ-020 err_timeout SHALL clear only on reset.
REQ-021 A req bit dropped before grant SHALL have no effect; req bits are not latched.
REQ-022 last_grant SHALL update only on a grant.
REQ-023 out_sin/out_cos SHALL hold their value outside DELIVER.

Reset
REQ-024 With resetn=0 at a clock edge, the block SHALL enter IDLE and set last_grant=NCH-1 (first search starts at channel 0).
REQ-025 During and after reset: ack=0, cordic_start=0, cordic_angle=0, cordic_x=0, cordic_y=0, out_valid=0, out_ch=0, out_sin=0, out_cos=0, err_timeout=0, timeout counter=0.
REQ-026 Reset in any state, including mid-WAIT, SHALL abort the operation; a later cordic_done SHALL be ignored.

Verification
REQ-027 After reset, req=4'b0001, ch_angle[0]=16'h007F, core done 12 cycles after start with sin=12'd100 -> ack[0] pulse, start one cycle later carrying angle 16'h007F, x=1215, y=0; out_valid with out_ch=0, out_sin=100.
REQ-028 req=4'b1111 held continuously -> grants in order 0,1,2,3,0; each ack exactly one cycle.
REQ-029 last_grant=3, req=4'b1001 -> grant 0 (wrap-around); the next grant is 3.
REQ-030 Core never asserts done, TMO=63 -> err_timeout=1 after 63 WAIT cycles, no out_valid, next grant proceeds, err_timeout stays 1.
REQ-031 cordic_done during ISSUE and during IDLE -> ignored; the result comes only from done in WAIT.
REQ-032 resetn=0 for one cycle mid-WAIT, then a late cordic_done -> all outputs 0, no out_valid, FSM in IDLE.
